// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM states, 8N1 frame constants and tick divider math shared by the UART blocks
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam int DATA_BITS = 8;

    function automatic int calc_div(input int clk_freq, input int baud_rate, input int os);
        return (clk_freq + baud_rate * os / 2) / (baud_rate * os);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick divider, one tick every DIV clocks, restartable by clear
module uart_baud_gen
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= clear || tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, oversampled 2-of-3 majority bit recovery, one-entry valid/ready holding register
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PH_S0  = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_DEC = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);

    state_t        state, state_n;
    logic [1:0]    sync;
    logic [1:0]    smp;
    logic [PW-1:0] phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          rx_s, tick, clear, decide, wrap, maj, stop_ok, stop_bad, pend;

    assign rx_s     = sync[1];
    assign busy     = state != IDLE;
    assign clear    = state == IDLE && !rx_s;
    assign decide   = tick && phase == PH_DEC;
    assign wrap     = tick && phase == PH_END;
    // third vote is the live sample at the decision phase
    assign maj      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign stop_ok  = state == STOP && decide && maj;
    assign stop_bad = state == STOP && decide && !maj;

    uart_baud_gen #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .tick(tick)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rx_s ? IDLE : START;
            START:   state_n = decide && maj ? IDLE : wrap ? DATA : START;
            DATA:    state_n = wrap && bit_cnt == 3'(DATA_BITS - 1) ? STOP : DATA;
            STOP:    state_n = !decide ? STOP : maj ? IDLE : BREAK;
            BREAK:   state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sync    <= 2'b11;
            smp     <= 2'b11;
            phase   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state <= state_n;
            sync  <= {sync[0], rx};
            phase <= clear ? '0 : tick ? (phase == PH_END ? '0 : phase + 1'b1) : phase;
            if (tick && phase == PH_S0) smp[0] <= rx_s;
            if (tick && phase == PH_S1) smp[1] <= rx_s;
            if (state == DATA && decide) shift <= {maj, shift[7:1]};
            if (state == START) bit_cnt <= '0;
            else if (state == DATA && wrap) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // delivery happens the cycle after the stop decision, against that cycle's valid/ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pend      <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= pend && valid && !ready;
            if (pend && (!valid || ready)) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed serial-line scenarios against uart_rx at default parameters (1 bit = 240 clk)
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    int errors = 0;
    int checks = 0;
    int valid_rises = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    logic valid_d = 1'b0;
    logic [7:0] got[$];

    uart_rx dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid(valid),
        .ready(ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && !valid_d) valid_rises++;
            if (valid && ready) got.push_back(data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
        end
        valid_d = valid;
    end

    function automatic logic [7:0] last_got();
        return got.size() > 0 ? got[got.size() - 1] : 8'hxx;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) rx = f[i];
            repeat (per - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk) rx = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk); #2 rst = 1'b0;
        idle(100);
    endtask

    task automatic test_single();
        int vr, n;
        vr = valid_rises; n = got.size();
        send_frame(8'h42, 1'b1, 240);
        idle(20);
        checks++; if (valid_rises - vr !== 1) begin errors++; $display("FAIL single_valid_pulses got=%0d exp=1", valid_rises - vr); end
        checks++; if (got.size() - n !== 1 || last_got() !== 8'h42) begin errors++; $display("FAIL single_byte got=%h n=%0d exp=42 n=1", last_got(), got.size() - n); end
        checks++; if (data !== 8'h42) begin errors++; $display("FAIL single_data got=%h exp=42", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_cleared got=%b exp=0", valid); end
        checks++; if (fe_cnt !== 0 || ov_cnt !== 0) begin errors++; $display("FAIL single_errors got fe=%0d ov=%0d exp 0 0", fe_cnt, ov_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_glitch();
        int vr, fe;
        vr = valid_rises; fe = fe_cnt;
        @(negedge clk) rx = 1'b0;
        repeat (29) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
        repeat (30) @(negedge clk);
        idle(170);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got=%b exp=0", busy); end
        checks++; if (valid_rises !== vr || fe_cnt !== fe) begin errors++; $display("FAIL glitch_no_output got valid=%0d fe=%0d exp valid=%0d fe=%0d", valid_rises, fe_cnt, vr, fe); end
        idle(100);
    endtask

    task automatic test_frame_err();
        int vr, fe, n;
        vr = valid_rises; fe = fe_cnt; n = got.size();
        send_frame(8'h55, 1'b0, 240);
        repeat (720) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got=%b exp=1", busy); end
        checks++; if (fe_cnt - fe !== 1) begin errors++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - fe); end
        checks++; if (valid_rises !== vr) begin errors++; $display("FAIL frame_err_no_valid got=%0d exp=%0d", valid_rises, vr); end
        idle(240);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit_busy got=%b exp=0", busy); end
        send_frame(8'hA5, 1'b1, 240);
        idle(20);
        checks++; if (got.size() - n !== 1 || last_got() !== 8'hA5) begin errors++; $display("FAIL after_break_byte got=%h n=%0d exp=a5 n=1", last_got(), got.size() - n); end
        checks++; if (fe_cnt - fe !== 1) begin errors++; $display("FAIL after_break_frame_err got=%0d exp=1", fe_cnt - fe); end
    endtask

    task automatic test_overrun();
        int vr, ov, fe, n;
        vr = valid_rises; ov = ov_cnt; fe = fe_cnt;
        @(posedge clk); #2 ready = 1'b0;
        n = got.size();
        send_frame(8'h11, 1'b1, 240);
        idle(240);
        send_frame(8'h22, 1'b1, 240);
        idle(20);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL overrun_valid_held got=%b exp=1", valid); end
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL overrun_data_kept got=%h exp=11", data); end
        checks++; if (ov_cnt - ov !== 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=1", ov_cnt - ov); end
        checks++; if (valid_rises - vr !== 1 || fe_cnt !== fe) begin errors++; $display("FAIL overrun_side got rises=%0d fe=%0d exp 1 %0d", valid_rises - vr, fe_cnt, fe); end
        @(posedge clk); #2 ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL consume_valid got=%b exp=0", valid); end
        checks++; if (got.size() - n !== 1 || last_got() !== 8'h11) begin errors++; $display("FAIL consume_byte got=%h n=%0d exp=11 n=1", last_got(), got.size() - n); end
        idle(50);
    endtask

    task automatic test_reset_midframe();
        logic [9:0] f;
        int n, fe;
        f = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) rx = f[i];
            repeat (239) @(negedge clk);
        end
        @(negedge clk) rx = f[4];
        repeat (119) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got=%b exp=1", busy); end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL async_reset got busy=%b valid=%b exp 0 0", busy, valid); end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        idle(480);
        n = got.size(); fe = fe_cnt;
        send_frame(8'h7E, 1'b1, 240);
        idle(20);
        checks++; if (got.size() - n !== 1 || last_got() !== 8'h7E) begin errors++; $display("FAIL post_reset_byte got=%h n=%0d exp=7e n=1", last_got(), got.size() - n); end
        checks++; if (fe_cnt !== fe) begin errors++; $display("FAIL post_reset_frame_err got=%0d exp=%0d", fe_cnt, fe); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int pers [2];
        int n, fe, ov;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h81;
        pers[0] = 234; pers[1] = 246;
        for (int p = 0; p < 2; p++) begin
            idle(240);
            n = got.size(); fe = fe_cnt; ov = ov_cnt;
            for (int k = 0; k < 3; k++) send_frame(exp[k], 1'b1, pers[p]);
            idle(20);
            checks++; if (got.size() - n !== 3) begin errors++; $display("FAIL b2b_count per=%0d got=%0d exp=3", pers[p], got.size() - n); end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got.size() <= n + k || got[n + k] !== exp[k]) begin
                    errors++;
                    $display("FAIL b2b_byte per=%0d idx=%0d got=%h exp=%h", pers[p], k, got.size() > n + k ? got[n + k] : 8'hxx, exp[k]);
                end
            end
            checks++; if (fe_cnt !== fe || ov_cnt !== ov) begin errors++; $display("FAIL b2b_errors per=%0d got fe=%0d ov=%0d exp fe=%0d ov=%0d", pers[p], fe_cnt, ov_cnt, fe, ov); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL err_and_overrun_same_cycle got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
